// File: rtl/ascon_ctrl_pkg.sv
// Shared definitions for the Ascon permutation register front-end:
// bus structs, register offsets, bit indices and the job FSM state type.
package ascon_ctrl_pkg;

    localparam int REG_AW = 32;
    localparam int REG_DW = 32;

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [REG_AW-1:0]     addr;
        logic [REG_DW-1:0]     wdata;
        logic [REG_DW/8-1:0]   wstrb;
    } reg_req_t;

    typedef struct packed {
        logic                  ready;
        logic [REG_DW-1:0]     rdata;
        logic                  error;
    } reg_rsp_t;

    localparam logic [REG_AW-1:0] ADDR_CTRL   = 32'h00;
    localparam logic [REG_AW-1:0] ADDR_STATUS = 32'h04;
    localparam logic [REG_AW-1:0] ADDR_STATE  = 32'h10;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ROUNDS = 8;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {IDLE, REQ, BUSY} job_state_e;

    // Default-geometry state array; the top uses its own parameterised shape.
    localparam int DEF_LANES  = 5;
    localparam int DEF_LANE_W = 64;
    typedef logic [DEF_LANES-1:0][DEF_LANE_W-1:0] ascon_state_t;

    // Byte-lane merge of a bus write into an existing register word.
    function automatic logic [REG_DW-1:0] apply_strb(
        input logic [REG_DW-1:0]   old_val,
        input logic [REG_DW-1:0]   wdata,
        input logic [REG_DW/8-1:0] wstrb
    );
        logic [REG_DW-1:0] res;
        res = old_val;
        for (int b = 0; b < REG_DW/8; b++) begin
            if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ascon_job_fsm.sv
// Job sequencer: start handshake toward the permutation core, busy tracking,
// and the one-cycle strobe that tells the register file to capture the result.
module ascon_job_fsm
    import ascon_ctrl_pkg::*;
#(
    parameter int ROUNDS_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [ROUNDS_W-1:0] rounds_i,
    input  logic                start_ready_i,
    input  logic                done_i,
    output logic                start_valid_o,
    output logic                busy_o,
    output logic                capture_o,
    output logic [ROUNDS_W-1:0] rounds_o
);

    job_state_e          state_q, state_d;
    logic [ROUNDS_W-1:0] rounds_q, rounds_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            rounds_q <= '0;
        end else begin
            state_q  <= state_d;
            rounds_q <= rounds_d;
        end
    end

    // rounds only reloads on IDLE->REQ, so it is stable for the whole job.
    always_comb begin
        state_d   = state_q;
        rounds_d  = rounds_q;
        capture_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = REQ;
                    rounds_d = rounds_i;
                end
            end
            REQ: begin
                if (start_ready_i) state_d = BUSY;
            end
            BUSY: begin
                if (done_i) begin
                    state_d   = IDLE;
                    capture_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_valid_o = (state_q == REQ);
    assign busy_o        = (state_q != IDLE);
    assign rounds_o      = rounds_q;

endmodule

// File: rtl/ascon_perm_ctrl_regs.sv
// Register front-end for the Ascon permutation core: native reg bus decode,
// state word storage, CTRL/STATUS registers and interrupt generation.
module ascon_perm_ctrl_regs
    import ascon_ctrl_pkg::*;
#(
    parameter int NUM_LANES = 5,
    parameter int LANE_W    = 64,
    parameter int BUS_W     = 32,
    parameter int ROUNDS_W  = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  reg_req_t                          reg_req_i,
    output reg_rsp_t                          reg_rsp_o,
    output logic                              start_valid_o,
    input  logic                              start_ready_i,
    output logic [ROUNDS_W-1:0]               rounds_o,
    input  logic                              done_i,
    input  logic [NUM_LANES-1:0][LANE_W-1:0]  state_i,
    output logic [NUM_LANES-1:0][LANE_W-1:0]  state_o,
    output logic                              busy_o,
    output logic                              irq_o
);

    localparam int NUM_WORDS = NUM_LANES * LANE_W / BUS_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [NUM_WORDS-1:0][BUS_W-1:0] words_q, words_d;
    logic                            irq_en_q, irq_en_d;
    logic [ROUNDS_W-1:0]             rounds_q, rounds_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;
    logic                            irq_q, irq_d;

    logic              wr, is_ctrl, is_stat, is_word, mapped;
    logic [REG_AW-1:0] woff;
    logic [IDX_W-1:0]  widx;
    logic              start_wr, start_go, start_err, word_err, capture;
    logic              clr_done, clr_err;
    logic [REG_DW-1:0] rdata;

    // ---------------- address decode ----------------
    assign wr      = reg_req_i.valid & reg_req_i.write;
    assign woff    = reg_req_i.addr - ADDR_STATE;
    assign widx    = woff[IDX_W+1:2];
    assign is_ctrl = (reg_req_i.addr == ADDR_CTRL);
    assign is_stat = (reg_req_i.addr == ADDR_STATUS);
    assign is_word = (reg_req_i.addr >= ADDR_STATE) && (woff[1:0] == 2'b00)
                   && ((woff >> 2) < REG_AW'(NUM_WORDS));
    assign mapped  = is_ctrl | is_stat | is_word;

    assign start_wr  = wr & is_ctrl & reg_req_i.wstrb[0] & reg_req_i.wdata[CTRL_START];
    assign start_go  = start_wr & ~busy_o;
    assign start_err = start_wr & busy_o;
    assign word_err  = wr & is_word & busy_o;
    assign clr_done  = wr & is_stat & reg_req_i.wstrb[0] & reg_req_i.wdata[STAT_DONE];
    assign clr_err   = wr & is_stat & reg_req_i.wstrb[0] & reg_req_i.wdata[STAT_ERR];

    // ---------------- job sequencer ----------------
    ascon_job_fsm #(
        .ROUNDS_W (ROUNDS_W)
    ) u_job_fsm (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .start_i       (start_go),
        .rounds_i      (rounds_d),
        .start_ready_i (start_ready_i),
        .done_i        (done_i),
        .start_valid_o (start_valid_o),
        .busy_o        (busy_o),
        .capture_o     (capture),
        .rounds_o      (rounds_o)
    );

    // ---------------- register next-state ----------------
    // Non-START CTRL fields still update on a rejected START while busy.
    always_comb begin
        irq_en_d = irq_en_q;
        rounds_d = rounds_q;
        if (wr && is_ctrl) begin
            if (reg_req_i.wstrb[CTRL_IRQ_EN/8]) irq_en_d = reg_req_i.wdata[CTRL_IRQ_EN];
            for (int b = 0; b < ROUNDS_W; b++) begin
                if (reg_req_i.wstrb[(CTRL_ROUNDS+b)/8])
                    rounds_d[b] = reg_req_i.wdata[CTRL_ROUNDS+b];
            end
        end
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    always_comb begin
        done_d = (done_q & ~clr_done) | capture;
        err_d  = (err_q & ~clr_err) | start_err | word_err;
        irq_d  = done_q & irq_en_q;
    end

    always_comb begin
        words_d = words_q;
        if (capture) begin
            words_d = state_i;
        end else if (wr && is_word && !busy_o) begin
            words_d[widx] = apply_strb(words_q[widx], reg_req_i.wdata, reg_req_i.wstrb);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            words_q  <= '0;
            irq_en_q <= 1'b0;
            rounds_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            words_q  <= words_d;
            irq_en_q <= irq_en_d;
            rounds_q <= rounds_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
        end
    end

    // ---------------- read path / response ----------------
    always_comb begin
        rdata = '0;
        if (is_ctrl) begin
            rdata[CTRL_IRQ_EN]               = irq_en_q;
            rdata[CTRL_ROUNDS +: ROUNDS_W]   = rounds_q;
        end else if (is_stat) begin
            rdata[STAT_BUSY] = busy_o;
            rdata[STAT_DONE] = done_q;
            rdata[STAT_ERR]  = err_q;
        end else if (is_word) begin
            rdata = words_q[widx];
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = reg_req_i.valid;
        reg_rsp_o.rdata = rdata;
        reg_rsp_o.error = reg_req_i.valid & (~mapped | start_err | word_err);
    end

    assign state_o = words_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_ascon_perm_ctrl_regs.sv
// Self-checking bench for ascon_perm_ctrl_regs: directed vector table, hand
// sequences for job/flag corner cases, and random traffic against a model.
module tb_ascon_perm_ctrl_regs;
    import ascon_ctrl_pkg::*;

    localparam int NL = 5;
    localparam int LW = 64;
    localparam int RW = 4;
    localparam int NW = NL * LW / 32;

    logic                    clk_i = 1'b0;
    logic                    rst_n_i = 1'b0;
    reg_req_t                req;
    reg_rsp_t                rsp;
    logic                    start_valid_o, start_ready_i, done_i, busy_o, irq_o;
    logic [RW-1:0]           rounds_o;
    logic [NL-1:0][LW-1:0]   state_i, state_o;

    always #5 clk_i = ~clk_i;

    ascon_perm_ctrl_regs #(
        .NUM_LANES (NL), .LANE_W (LW), .BUS_W (32), .ROUNDS_W (RW)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .reg_req_i     (req),
        .reg_rsp_o     (rsp),
        .start_valid_o (start_valid_o),
        .start_ready_i (start_ready_i),
        .rounds_o      (rounds_o),
        .done_i        (done_i),
        .state_i       (state_i),
        .state_o       (state_o),
        .busy_o        (busy_o),
        .irq_o         (irq_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: registers as plain variables, the job as two booleans.
    logic [31:0] m_w [NW];
    bit          m_irq_en, m_done, m_err, m_irq;
    bit          m_job_requested, m_job_running;
    logic [3:0]  m_rounds, m_job_rounds;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NW; k++) m_w[k] = '0;
        m_irq_en = 0; m_done = 0; m_err = 0; m_irq = 0;
        m_job_requested = 0; m_job_running = 0;
        m_rounds = '0; m_job_rounds = '0;
    endtask

    // One bus cycle: drive, check against the model at negedge, advance model at posedge.
    task automatic step(input bit v, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sb, input bit rdy, input bit dn,
                        output logic [31:0] rd, output bit er);
        bit is_ctrl, is_stat, is_word, busy, exp_err, start_try, err_set, done_set;
        int k;
        logic [31:0] exp_rd;
        logic [NL*LW-1:0] mflat, sflat, oflat;
        bit n_irq_en, n_done, n_err, n_req, n_run;
        logic [3:0] n_rounds, n_jr;

        req.valid = v; req.write = wr; req.addr = a; req.wdata = wd; req.wstrb = sb;
        start_ready_i = rdy; done_i = dn;
        @(negedge clk_i);
        rd = rsp.rdata; er = rsp.error;

        busy    = m_job_requested | m_job_running;
        is_ctrl = (a == 32'h0);
        is_stat = (a == 32'h4);
        is_word = (a >= 32'h10) && (a <= 32'h10 + 4 * (NW - 1)) && (a[1:0] == 2'b00);
        k       = is_word ? int'((a - 32'h10) / 4) : 0;
        if (is_ctrl)      exp_rd = (32'(m_rounds) << 8) + (32'(m_irq_en) << 1);
        else if (is_stat) exp_rd = 32'(m_err) * 4 + 32'(m_done) * 2 + 32'(busy);
        else if (is_word) exp_rd = m_w[k];
        else              exp_rd = 32'h0;
        start_try = wr && is_ctrl && sb[0] && wd[0];
        exp_err   = !(is_ctrl || is_stat || is_word) || (wr && busy && is_word) || (busy && start_try);

        if (v) begin
            chk("ready", 64'(rsp.ready), 64'(1'b1));
            chk("error", 64'(er), 64'(exp_err));
            if (!wr) chk("rdata", 64'(rd), 64'(exp_rd));
        end
        chk("start_valid", 64'(start_valid_o), 64'(m_job_requested));
        chk("busy", 64'(busy_o), 64'(busy));
        chk("irq", 64'(irq_o), 64'(m_irq));
        chk("rounds_o", 64'(rounds_o), 64'(m_job_rounds));
        for (int j = 0; j < NW; j++) mflat[j*32 +: 32] = m_w[j];
        oflat = state_o;
        n_chk++;
        if (oflat !== mflat) begin
            n_fail++;
            $display("FAIL state_o: got %h expected %h", oflat[63:0], mflat[63:0]);
        end

        n_irq_en = m_irq_en; n_rounds = m_rounds; n_jr = m_job_rounds;
        n_done = m_done; n_err = m_err; n_req = m_job_requested; n_run = m_job_running;
        err_set = 0; done_set = 0;
        if (v && wr && is_ctrl) begin
            if (sb[0]) n_irq_en = wd[1];
            if (sb[1]) n_rounds = wd[11:8];
            if (start_try && busy) err_set = 1;
            if (start_try && !busy) begin
                n_req = 1;
                n_jr  = sb[1] ? wd[11:8] : m_rounds;
            end
        end
        if (v && wr && is_stat && sb[0]) begin
            if (wd[1]) n_done = 0;
            if (wd[2]) n_err = 0;
        end
        if (v && wr && is_word) begin
            if (busy) err_set = 1;
            else for (int b = 0; b < 4; b++) if (sb[b]) m_w[k][b*8 +: 8] = wd[b*8 +: 8];
        end
        if (m_job_requested && rdy) begin n_req = 0; n_run = 1; end
        if (m_job_running && dn) begin
            sflat = state_i;
            for (int j = 0; j < NW; j++) m_w[j] = sflat[j*32 +: 32];
            done_set = 1;
            n_run = 0;
        end
        m_irq = m_done & m_irq_en;
        m_irq_en = n_irq_en; m_rounds = n_rounds; m_job_rounds = n_jr;
        m_done = n_done | done_set; m_err = n_err | err_set;
        m_job_requested = n_req; m_job_running = n_run;

        @(posedge clk_i); #1;
        req.valid = 0; done_i = 0;
    endtask

    task automatic rd_(input logic [31:0] a, output logic [31:0] d, output bit e);
        step(1, 0, a, 32'h0, 4'h0, 0, 0, d, e);
    endtask

    task automatic wr_(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sb, output bit e);
        logic [31:0] x;
        step(1, 1, a, d, sb, 0, 0, x, e);
    endtask

    task automatic idle(input bit rdy, input bit dn);
        logic [31:0] x; bit e;
        step(0, 0, 32'h0, 32'h0, 4'h0, rdy, dn, x, e);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] d;
        bit e;
        logic [319:0] sflat;
        logic [63:0]  lane0;

        req = '0; start_ready_i = 0; done_i = 0; state_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); rst_n_i = 1;
        @(posedge clk_i); #1;

        // Reset view: every mapped register reads zero.
        rd_(32'h04, d, e); chk("reset_status", 64'(d), 64'h0);
        for (int k = 0; k < NW; k++) begin
            rd_(32'h10 + 32'(4 * k), d, e);
            chk("reset_word", 64'(d), 64'h0);
        end
        chk("reset_irq", 64'(irq_o), 64'h0);

        vecs.push_back('{1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0});
        vecs.push_back('{1, 32'h14, 32'h01234567, 4'hF, 32'h0, 0});
        vecs.push_back('{0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0});
        vecs.push_back('{0, 32'h14, 32'h0,        4'h0, 32'h01234567, 0});
        vecs.push_back('{1, 32'h14, 32'h000000FF, 4'h1, 32'h0, 0});
        vecs.push_back('{0, 32'h14, 32'h0,        4'h0, 32'h012345FF, 0});
        vecs.push_back('{1, 32'h18, 32'h11223344, 4'hC, 32'h0, 0});
        vecs.push_back('{0, 32'h18, 32'h0,        4'h0, 32'h11220000, 0});
        vecs.push_back('{0, 32'h08, 32'h0,        4'h0, 32'h0, 1});
        vecs.push_back('{0, 32'h40, 32'h0,        4'h0, 32'h0, 1});
        vecs.push_back('{1, 32'h0C, 32'h12345678, 4'hF, 32'h0, 1});
        vecs.push_back('{0, 32'h12, 32'h0,        4'h0, 32'h0, 1});
        vecs.push_back('{1, 32'h00, 32'h00000302, 4'hF, 32'h0, 0});
        vecs.push_back('{0, 32'h00, 32'h0,        4'h0, 32'h00000302, 0});
        vecs.push_back('{0, 32'h34, 32'h0,        4'h0, 32'h0, 0});
        foreach (vecs[i]) begin
            step(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0, 0, d, e);
            chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), 64'(d), 64'(vecs[i].exp_rd));
        end
        sflat = state_o;
        chk("state_o_lane0", sflat[63:0], 64'h012345FF_DEADBEEF);

        // Job: start with irq_en and rounds=12, core stalls 3 cycles.
        wr_(32'h00, 32'h00000C03, 4'hF, e);
        for (int i = 0; i < 3; i++) begin
            chk("req_valid", 64'(start_valid_o), 64'h1);
            chk("req_rounds", 64'(rounds_o), 64'd12);
            idle(0, 0);
        end
        idle(1, 0);
        chk("busy_after_accept", 64'(busy_o), 64'h1);
        chk("valid_after_accept", 64'(start_valid_o), 64'h0);
        wr_(32'h18, 32'h1, 4'hF, e); chk("busy_word_wr_err", 64'(e), 64'h1);
        rd_(32'h18, d, e);           chk("busy_word_kept", 64'(d), 64'h11220000);
        rd_(32'h04, d, e);           chk("busy_status", 64'(d), 64'h5);
        wr_(32'h00, 32'h00000C03, 4'hF, e); chk("busy_start_err", 64'(e), 64'h1);
        idle(0, 0);
        chk("no_second_job", 64'(start_valid_o), 64'h0);
        wr_(32'h04, 32'h4, 4'hF, e);
        for (int l = 0; l < NL; l++) state_i[l] = {$urandom, $urandom};
        state_i[0] = 64'hA5A5A5A5_A5A5A5A5;
        idle(0, 1);
        rd_(32'h04, d, e); chk("done_status", 64'(d), 64'h2);
        rd_(32'h10, d, e); chk("capture_word0", 64'(d), 64'hA5A5A5A5);
        chk("irq_set", 64'(irq_o), 64'h1);

        // Same-cycle DONE set and W1C clear.
        wr_(32'h04, 32'h2, 4'hF, e);
        wr_(32'h00, 32'h00000C03, 4'hF, e);
        idle(1, 0);
        step(1, 1, 32'h04, 32'h2, 4'hF, 0, 1, d, e);
        rd_(32'h04, d, e); chk("set_wins", 64'(d), 64'h2);
        wr_(32'h04, 32'h2, 4'hF, e);
        rd_(32'h04, d, e); chk("done_cleared", 64'(d), 64'h0);
        idle(0, 0);
        chk("irq_fall", 64'(irq_o), 64'h0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a, wd;
            for (int l = 0; l < NL; l++) state_i[l] = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: a = 32'h00;
                1: a = 32'h04;
                2, 3: a = 32'h10 + 4 * $urandom_range(0, NW - 1);
                4: a = 32'h08;
                default: a = 32'h40;
            endcase
            wd = $urandom;
            if (a == 32'h0 && $urandom_range(0, 1) == 1) wd[0] = 1'b1;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, wd,
                 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, d, e);
        end

        // Reset in the middle of a job.
        wr_(32'h04, 32'h6, 4'hF, e);
        while (busy_o) idle(1, 1);
        wr_(32'h00, 32'h00000001, 4'h1, e);
        idle(1, 0);
        chk("busy_before_rst", 64'(busy_o), 64'h1);
        #2 rst_n_i = 0;
        #1;
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_rounds", 64'(rounds_o), 64'h0);
        model_reset();
        @(negedge clk_i); rst_n_i = 1;
        @(posedge clk_i); #1;
        for (int l = 0; l < NL; l++) state_i[l] = {$urandom, $urandom};
        idle(0, 1);
        rd_(32'h04, d, e); chk("rst_no_done", 64'(d), 64'h0);
        rd_(32'h10, d, e); chk("rst_no_capture", 64'(d), 64'h0);
        rd_(32'h40, d, e); chk("unmapped_err", 64'(e), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_perm_ctrl_regs.md
Name: ascon_perm_ctrl_regs

Overview:
Parametrised register front-end and job sequencer for the Ascon permutation core. It decodes reg_req_t accesses natively instead of using a generated reg_top. It holds the permutation state as BUS_W-bit words and hands jobs to the core over a valid/ready start handshake. It captures the result on core completion and raises a sticky done flag and an optional interrupt. It sits between the peripheral reg bus and the permutation datapath.

Parameters:
NUM_LANES, 5, number of state lanes
LANE_W, 64, lane width in bits
BUS_W, 32, register bus data width; LANE_W must be a multiple of BUS_W
ROUNDS_W, 4, width of the rounds field passed to the core
NUM_WORDS, NUM_LANES*LANE_W/BUS_W (derived, localparam), number of state words (10 by default)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
reg_req_i  in  reg_req_t  bus request (valid, write, addr, wdata, wstrb)
reg_rsp_o  out  reg_rsp_t  bus response (ready, rdata, error)
start_valid_o  out  1  job request to core
start_ready_i  in  1  core accepts job
rounds_o  out  ROUNDS_W  round count for the current job
done_i  in  1  single-cycle core completion pulse
state_i  in  NUM_LANES x LANE_W  core result state
state_o  out  NUM_LANES x LANE_W  state presented to core
busy_o  out  1  job in flight
irq_o  out  1  level interrupt

Behaviour:
- Reset: all state words 0, CTRL 0, STATUS 0, FSM IDLE. All outputs 0. rounds_o resets to 0.
- Register map (byte addresses, BUS_W=32):
  - 0x00 CTRL: bit0 START (write-1 triggers, reads 0); bit1 IRQ_EN; bits[8+ROUNDS_W-1:8] ROUNDS.
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, W1C); bit2 ERR (sticky, W1C).
  - 0x10 + 4k: state word k, k = 0..NUM_WORDS-1. Word 2i is lane i [31:0]; word 2i+1 is lane i [63:32].
- Bus timing:
  - reg_rsp_o.ready = 1 combinationally whenever valid.
  - rdata is combinational from current registers. Writes take effect on the next edge and honour wstrb per byte.
  - Unmapped address: error=1, rdata=0, no side effects.
- FSM:
  - IDLE: a START write moves to REQ. ROUNDS is latched into rounds_o from the same write's wdata if the CTRL write carries it, else from the stored ROUNDS value.
  - REQ: start_valid_o=1 until start_ready_i=1, then move to BUSY. Latency from START write to start_valid_o is 1 cycle.
  - BUSY: on done_i, capture state_i into all state words, set DONE, move to IDLE.
  - busy_o = 1 in REQ or BUSY.
- state_o is a continuous view of the state words.
- Errors while busy_o=1:
  - A write to state words gets error=1, the write is dropped, and ERR is set.
  - A START write gets error=1, is ignored, and sets ERR. Other CTRL bits in that write still update.
  - Reads are always allowed.
- done_i outside BUSY: ignored, no capture.
- Same-cycle DONE set and W1C clear: set wins. The same rule applies to ERR.
- irq_o = DONE & IRQ_EN, registered (1-cycle delay from the DONE flop).
- rounds_o is held stable from REQ entry through BUSY.
- Reset mid-job: FSM returns to IDLE and all flags and state clear. A subsequent done_i is ignored.

Decomposition:
- Shared package (ascon_ctrl_pkg):
  - address offset constants;
  - CTRL/STATUS bit-index constants;
  - FSM enum typedef {IDLE, REQ, BUSY};
  - state array typedef parametrised in width.
- One sub-module is natural: ascon_job_fsm (start handshake, busy, done capture strobe). Register decode and storage stay in the top.

Test Plan:
- Reset, then read 0x04 and 0x10..0x34 -> all rdata 0; start_valid_o=0, irq_o=0.
- Write 0x10=0xDEADBEEF and 0x14=0x01234567 -> state_o[0]=0x01234567_DEADBEEF. Write 0x14 with wstrb=0b0001 and wdata=0xFF -> upper word becomes 0x012345FF.
- Write 0x00=0x0C03 (start, irq_en, rounds=12), hold start_ready_i=0 for 3 cycles -> start_valid_o high 3 cycles from 1 cycle after the write, rounds_o=12. Raise start_ready_i -> busy_o stays 1. Pulse done_i with state_i lane0=0xA5A5... -> STATUS reads 0x2, word 0 reads 0xA5A5A5A5, irq_o=1 one cycle later.
- While BUSY, write 0x18=0x1 -> error=1, word 2 unchanged, STATUS.ERR=1. START write while BUSY -> error=1, no second job.
- Write 0x04=0x2 in the same cycle done_i pulses -> DONE remains 1. Next W1C 0x2 -> DONE=0, irq_o falls 1 cycle later.
- Assert rst_n_i low in BUSY -> busy_o=0 immediately. After release, done_i pulse -> no capture, DONE=0. Access 0x40 -> error=1.
